// File: rtl/input_port_buffer.sv
// Router input port: a small circular flit FIFO with a packet FSM that
// latches the route of each header, requests one output port from the
// arbiter while the packet is active, and forwards granted flits on a
// registered output. Flits that cannot belong to a routable packet are
// popped and discarded with a one-cycle drop_err pulse.
//
// Handshake: a flit moves upstream->buffer on any rising edge where
// flit_in_valid && flit_in_ready; flit_in_ready depends only on registered
// occupancy (never on a same-cycle pop), and valid must not depend on ready.
module input_port_buffer #(
  parameter int DEPTH  = 4,
  parameter int FLIT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [FLIT_W-1:0]        flit_in,
  input  logic                     flit_in_valid,
  output logic                     flit_in_ready,
  output logic [FLIT_W-1:0]        head_flit,
  input  logic [4:0]               route_onehot,
  output logic [4:0]               req,
  input  logic                     grant,
  output logic [FLIT_W-1:0]        flit_out,
  output logic                     flit_out_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     drop_err,
  output logic                     fsm_state
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [FLIT_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count_q;
  logic [4:0]         route_reg;

  logic               wr_en;
  logic               pop;
  logic               drop;
  logic               fwd;
  logic               latch_route;
  logic               non_empty;
  logic               route_ok;
  logic [1:0]         head_type;

  assign non_empty     = (count_q != '0);
  assign flit_in_ready = (count_q != CNT_W'(DEPTH));
  assign wr_en         = flit_in_valid && flit_in_ready;
  assign head_flit     = non_empty ? mem[rd_ptr] : '0;
  assign head_type     = head_flit[FLIT_W-1 -: 2];
  assign route_ok      = (route_onehot != 5'd0) &&
                         ((route_onehot & (route_onehot - 5'd1)) == 5'd0);
  assign count         = count_q;
  assign fsm_state     = state_q;

  // Flit storage; contents are only observed through head_flit, which is
  // masked to zero when empty, so the array needs no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= flit_in;
    end
  end

  // Pointers and occupancy; a write and a pop in the same cycle leave count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      count_q <= count_q + CNT_W'(wr_en) - CNT_W'(pop);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a cleanly routed header opens a packet; popping a tail or
  // single-flit header closes it. A type-10 flit mid-packet is just a body.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (non_empty && head_type[1] && route_ok) state_d = ACTIVE;
      end
      ACTIVE: begin
        if (grant && non_empty && head_type[0]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: route latch, discard pop, forward pop and the arbiter request.
  always_comb begin
    latch_route = 1'b0;
    drop        = 1'b0;
    fwd         = 1'b0;
    req         = 5'd0;
    case (state_q)
      IDLE: begin
        if (non_empty) begin
          if (head_type[1] && route_ok) latch_route = 1'b1;
          else                          drop        = 1'b1;
        end
      end
      ACTIVE: begin
        if (non_empty) begin
          req = route_reg;
          fwd = grant;
        end
      end
      default: ;
    endcase
    pop = drop || fwd;
  end

  // Latched route for the packet currently being forwarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      route_reg <= 5'd0;
    end else if (latch_route) begin
      route_reg <= route_onehot;
    end
  end

  // Registered crossbar output and discard pulse; flit_out holds between pops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flit_out       <= '0;
      flit_out_valid <= 1'b0;
      drop_err       <= 1'b0;
    end else begin
      flit_out_valid <= fwd;
      drop_err       <= drop;
      if (fwd) flit_out <= head_flit;
    end
  end

endmodule

// File: tb/tb_input_port_buffer.sv
// Directed bench for input_port_buffer: each scenario drives a short flit
// sequence and compares outputs against hand-computed values one time
// unit after each rising edge.
module tb_input_port_buffer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] flit_in;
  logic       flit_in_valid;
  logic       flit_in_ready;
  logic [7:0] head_flit;
  logic [4:0] route_onehot;
  logic [4:0] req;
  logic       grant;
  logic [7:0] flit_out;
  logic       flit_out_valid;
  logic [2:0] count;
  logic       drop_err;
  logic       fsm_state;

  int checks   = 0;
  int failures = 0;

  input_port_buffer #(.DEPTH(4), .FLIT_W(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .flit_in        (flit_in),
    .flit_in_valid  (flit_in_valid),
    .flit_in_ready  (flit_in_ready),
    .head_flit      (head_flit),
    .route_onehot   (route_onehot),
    .req            (req),
    .grant          (grant),
    .flit_out       (flit_out),
    .flit_out_valid (flit_out_valid),
    .count          (count),
    .drop_err       (drop_err),
    .fsm_state      (fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] f);
    flit_in       = f;
    flit_in_valid = 1'b1;
  endtask

  task automatic idle_in();
    flit_in_valid = 1'b0;
    flit_in       = 8'h00;
  endtask

  initial begin
    rst = 1'b1;
    idle_in();
    route_onehot = 5'd0;
    grant        = 1'b0;
    repeat (3) step();

    // reset state
    check("rst_count", count, 0);
    check("rst_ready", flit_in_ready, 1);
    check("rst_req", req, 0);
    check("rst_fout", flit_out, 0);
    check("rst_fvalid", flit_out_valid, 0);
    check("rst_drop", drop_err, 0);
    check("rst_head", head_flit, 0);
    check("rst_state", fsm_state, 0);
    rst = 1'b0;
    step();

    // three-flit packet, grant held
    route_onehot = 5'b00010;
    grant        = 1'b1;
    push(8'h87);
    step();
    check("p1_head", head_flit, 8'h87);
    check("p1_req_latch", req, 0);
    push(8'h05);
    step();
    check("p1_req", req, 5'b00010);
    check("p1_count2", count, 2);
    push(8'h45);
    step();
    idle_in();
    check("p1_out0", flit_out, 8'h87);
    check("p1_v0", flit_out_valid, 1);
    check("p1_req_hold", req, 5'b00010);
    step();
    check("p1_out1", flit_out, 8'h05);
    check("p1_v1", flit_out_valid, 1);
    step();
    check("p1_out2", flit_out, 8'h45);
    check("p1_v2", flit_out_valid, 1);
    check("p1_req_end", req, 0);
    check("p1_state_end", fsm_state, 0);
    check("p1_count_end", count, 0);
    grant = 1'b0;
    step();
    check("p1_v_after", flit_out_valid, 0);
    check("p1_out_hold", flit_out, 8'h45);

    // fill to full with grant low, 5th flit refused
    route_onehot = 5'b00001;
    push(8'h81); step();
    push(8'h02); step();
    check("f_state", fsm_state, 1);
    push(8'h03); step();
    push(8'h44); step();
    check("f_count4", count, 4);
    push(8'h09);
    check("f_ready0", flit_in_ready, 0);
    step();
    check("f_count_still4", count, 4);
    check("f_head", head_flit, 8'h81);
    check("f_no_out", flit_out_valid, 0);

    // full, grant and valid together: one pop, no write
    grant = 1'b1;
    push(8'h06);
    step();
    idle_in();
    check("fp_count3", count, 3);
    check("fp_out", flit_out, 8'h81);
    check("fp_v", flit_out_valid, 1);
    step();
    check("fp_out1", flit_out, 8'h02);
    step();
    check("fp_out2", flit_out, 8'h03);
    step();
    check("fp_out3", flit_out, 8'h44);
    check("fp_count0", count, 0);
    check("fp_state", fsm_state, 0);
    grant = 1'b0;
    step();
    check("fp_v_end", flit_out_valid, 0);

    // orphan body in IDLE
    push(8'h01);
    step();
    idle_in();
    check("orph_count1", count, 1);
    check("orph_drop0", drop_err, 0);
    step();
    check("orph_drop", drop_err, 1);
    check("orph_count0", count, 0);
    check("orph_fv", flit_out_valid, 0);
    step();
    check("orph_drop_end", drop_err, 0);

    // header with multi-hot route is discarded
    route_onehot = 5'b00011;
    push(8'h87);
    step();
    idle_in();
    step();
    check("mh_drop", drop_err, 1);
    check("mh_count", count, 0);
    check("mh_state", fsm_state, 0);
    step();

    // single-flit packet
    route_onehot = 5'b00001;
    grant        = 1'b1;
    push(8'hC5);
    step();
    idle_in();
    check("s_head", head_flit, 8'hC5);
    step();
    check("s_req", req, 5'b00001);
    check("s_state_act", fsm_state, 1);
    step();
    check("s_out", flit_out, 8'hC5);
    check("s_v", flit_out_valid, 1);
    check("s_state_idle", fsm_state, 0);
    check("s_req0", req, 0);
    step();
    check("s_v_end", flit_out_valid, 0);
    grant = 1'b0;

    // asynchronous reset mid-packet
    route_onehot = 5'b00010;
    push(8'h87); step();
    push(8'h05); step();
    push(8'h05); step();
    idle_in();
    check("ar_count3", count, 3);
    check("ar_req", req, 5'b00010);
    #2 rst = 1'b1;
    #1;
    check("ar_count0", count, 0);
    check("ar_req0", req, 0);
    check("ar_fv0", flit_out_valid, 0);
    check("ar_head0", head_flit, 0);
    step();
    rst = 1'b0;
    push(8'h45);
    step();
    idle_in();
    step();
    check("ar_orph_drop", drop_err, 1);
    check("ar_orph_count", count, 0);
    check("ar_orph_state", fsm_state, 0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
